t03_gpio_bank: RTL

Parametrised memory-mapped GPIO bank, successor to the single-register IO enable block. It sits between the CPU data-memory port and the chip pads. It decodes a contiguous window of eight register addresses starting at `BASE_ADDR` and passes all other reads through from memory. Beyond plain output, enable and input registers it provides:
- atomic set/clear of output bits;
- a configurable-depth input synchroniser;
- per-bit edge detection with a masked interrupt.

---
 rtl/t03_gpio_bank.sv | 133 +++++++++++++
 1 files changed

// File: rtl/t03_gpio_bank.sv
// rtl/t03_gpio_bank.sv - memory-mapped GPIO bank; edge detect/irq built only with T03_GPIO_EDGE_IRQ_EN
module t03_gpio_bank #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFF0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             write_mem,
    input  logic             read_mem,
    input  logic [31:0]      data_address,
    input  logic [31:0]      data_to_write,
    input  logic [31:0]      data_from_mem,
    output logic [31:0]      data_read,
    output logic [WIDTH-1:0] IO_out,
    output logic [WIDTH-1:0] IO_enable,
    input  logic [WIDTH-1:0] IO_in,
    output logic             irq
);

    localparam logic [2:0] OFS_OUT   = 3'd0;
    localparam logic [2:0] OFS_SET   = 3'd1;
    localparam logic [2:0] OFS_CLR   = 3'd2;
    localparam logic [2:0] OFS_EN    = 3'd3;
    localparam logic [2:0] OFS_IN    = 3'd4;
    localparam logic [2:0] OFS_STAT  = 3'd5;
    localparam logic [2:0] OFS_MASK  = 3'd6;
    localparam logic [2:0] OFS_POL   = 3'd7;

    logic [31:0]      offset_full;
    logic             hit;
    logic [2:0]       offset;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] en_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [31:0]      reg_val;

    // The subtraction wraps, so one unsigned compare covers both ends of the window.
    assign offset_full = data_address - BASE_ADDR;
    assign hit         = (offset_full < 32'd8);
    assign offset      = offset_full[2:0];
    assign wr_en       = write_mem & hit;
    assign wdata       = data_to_write[WIDTH-1:0];
    assign sync        = sync_q[SYNC_STAGES-1];

    assign IO_out    = out_q;
    assign IO_enable = en_q;

    // Output and enable registers, including atomic set/clear of output bits.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_q <= '0;
            en_q  <= '0;
        end else if (wr_en) begin
            case (offset)
                OFS_OUT: out_q <= wdata;
                OFS_SET: out_q <= out_q | wdata;
                OFS_CLR: out_q <= out_q & ~wdata;
                OFS_EN:  en_q  <= wdata;
                default: ;
            endcase
        end
    end

    // Pad input synchroniser chain; the last stage is the architectural IN value.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= IO_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef T03_GPIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] edge_pol;
    logic [WIDTH-1:0] edge_mask;
    logic [WIDTH-1:0] edge_stat;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c;
    logic             irq_q;

    assign edge_det = (edge_pol & sync & ~sync_d) | (~edge_pol & ~sync & sync_d);
    assign w1c      = (wr_en && offset == OFS_STAT) ? wdata : '0;
    assign irq      = irq_q;

    // Edge status is sticky; a fresh edge beats a simultaneous W1C on the same bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_d    <= '0;
            edge_stat <= '0;
            edge_mask <= '0;
            edge_pol  <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync_d    <= sync;
            edge_stat <= (edge_stat & ~w1c) | edge_det;
            irq_q     <= |(edge_stat & edge_mask);
            if (wr_en && offset == OFS_MASK) edge_mask <= wdata;
            if (wr_en && offset == OFS_POL)  edge_pol  <= wdata;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Register readback mux; write-only and absent registers read as zero.
    always_comb begin
        reg_val = '0;
        case (offset)
            OFS_OUT:  reg_val[WIDTH-1:0] = out_q;
            OFS_EN:   reg_val[WIDTH-1:0] = en_q;
            OFS_IN:   reg_val[WIDTH-1:0] = sync;
`ifdef T03_GPIO_EDGE_IRQ_EN
            OFS_STAT: reg_val[WIDTH-1:0] = edge_stat;
            OFS_MASK: reg_val[WIDTH-1:0] = edge_mask;
            OFS_POL:  reg_val[WIDTH-1:0] = edge_pol;
`endif
            default:  reg_val = '0;
        endcase
    end

    // Mapped loads return register data; everything else, and any load under reset, sees memory.
    always_comb begin
        data_read = data_from_mem;
        if (read_mem && hit && nrst) data_read = reg_val;
    end

endmodule
